// File: rtl/delay_line.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : delay_line
// Description : Fixed-latency register chain delaying signal_in by
//               DELAY_CYCLES clk edges. Optional macro DELAY_LINE_PENDING_EN
//               adds a registered 'pending' flag (nonzero data in flight).
// Revision    : 1.0 - initial release
// ============================================================================
module delay_line #(
    parameter int DELAY_CYCLES = 4,
    parameter int WIDTH        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] signal_in,
    output logic [WIDTH-1:0] signal_out
`ifdef DELAY_LINE_PENDING_EN
    ,
    output logic             pending
`endif
);

    if (WIDTH < 1) begin : g_bad_width
        $error("delay_line: WIDTH must be >= 1");
    end

    if (DELAY_CYCLES < 0) begin : g_bad_delay
        $error("delay_line: DELAY_CYCLES must be >= 0");
        assign signal_out = '0;
`ifdef DELAY_LINE_PENDING_EN
        assign pending = 1'b0;
`endif
        wire w_unused = &{1'b0, clk, reset, signal_in};
    end else if (DELAY_CYCLES == 0) begin : g_passthru
        // Pure wire: no state, so reset cannot affect the output.
        assign signal_out = signal_in;
`ifdef DELAY_LINE_PENDING_EN
        assign pending = 1'b0;
`endif
        wire w_unused = &{1'b0, clk, reset};
    end else begin : g_chain
        logic [WIDTH-1:0] r_stage [DELAY_CYCLES];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DELAY_CYCLES; i++) begin
                    r_stage[i] <= '0;
                end
            end else begin
                r_stage[0] <= signal_in;
                for (int i = 1; i < DELAY_CYCLES; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign signal_out = r_stage[DELAY_CYCLES-1];

`ifdef DELAY_LINE_PENDING_EN
        // Flag is computed from the chain's next-state so it lines up with
        // the stage contents after the same edge.
        logic w_next_any;
        logic r_pending;

        always_comb begin
            w_next_any = |signal_in;
            for (int i = 0; i < DELAY_CYCLES - 1; i++) begin
                w_next_any = w_next_any | (|r_stage[i]);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_pending <= 1'b0;
            end else begin
                r_pending <= w_next_any;
            end
        end

        assign pending = r_pending;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_delay_line.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_delay_line
// Description : Randomized scoreboard bench for delay_line (DELAY=4, WIDTH=8)
//               plus a zero-delay instance checked against its input.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_line;

    localparam int D = 4;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        logic         pend;
    } exp_t;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic [W-1:0] signal_in = '0;
    logic [W-1:0] signal_out;
    logic [W-1:0] signal_out0;
`ifdef DELAY_LINE_PENDING_EN
    logic         pending;
    logic         pending0;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] pipe  [$];
    exp_t         exp_q [$];
    bit           model_on = 1'b0;

    delay_line #(.DELAY_CYCLES(D), .WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .signal_in  (signal_in),
        .signal_out (signal_out)
`ifdef DELAY_LINE_PENDING_EN
        ,
        .pending    (pending)
`endif
    );

    delay_line #(.DELAY_CYCLES(0), .WIDTH(W)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .signal_in  (signal_in),
        .signal_out (signal_out0)
`ifdef DELAY_LINE_PENDING_EN
        ,
        .pending    (pending0)
`endif
    );

    always #5 clk = ~clk;

    // Reference: the output is the oldest of the last D samples; reset
    // replaces the whole window with zeros.
    initial begin : model
        exp_t e;
        forever begin
            @(posedge clk);
            if (reset) begin
                pipe.delete();
                for (int i = 0; i < D; i++) pipe.push_back('0);
                model_on = 1'b1;
            end else if (model_on) begin
                pipe.push_back(signal_in);
                void'(pipe.pop_front());
            end
            if (model_on) begin
                e.data = pipe[0];
                e.pend = 1'b0;
                foreach (pipe[i]) if (pipe[i] != '0) e.pend = 1'b1;
                exp_q.push_back(e);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (signal_out !== e.data) begin
                    bad++;
                    $display("FAIL out t=%0t actual=%h required=%h", $time, signal_out, e.data);
                end
`ifdef DELAY_LINE_PENDING_EN
                total++;
                if (pending !== e.pend) begin
                    bad++;
                    $display("FAIL pending t=%0t actual=%b required=%b", $time, pending, e.pend);
                end
                total++;
                if (pending0 !== 1'b0) begin
                    bad++;
                    $display("FAIL pending0 t=%0t actual=%b required=0", $time, pending0);
                end
`endif
            end
            total++;
            if (signal_out0 !== signal_in) begin
                bad++;
                $display("FAIL zero_delay t=%0t actual=%h required=%h", $time, signal_out0, signal_in);
            end
        end
    end

    task automatic step(input logic r, input logic [W-1:0] v);
        @(negedge clk);
        reset     = r;
        signal_in = v;
    endtask

    initial begin : stim
        logic [W-1:0] v;
        // Reset hold with toggling input.
        for (int i = 0; i < 4; i++) step(1'b1, (i % 2 == 0) ? 8'hFF : 8'h00);
        step(1'b1, 8'hA5);
        for (int i = 0; i < D + 2; i++) step(1'b0, 8'h00);
        // Single-cycle pulse.
        step(1'b0, 8'h01);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00);
        // Back-to-back pattern 0x01..0x10.
        for (int i = 1; i <= 16; i++) step(1'b0, W'(i));
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00);
        // Reset two edges after a pulse: pulse must never emerge.
        step(1'b0, 8'h5A);
        step(1'b0, 8'h00);
        step(1'b1, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00);
        // Reset coinciding with nonzero input.
        step(1'b1, 8'hC3);
        for (int i = 0; i < D + 1; i++) step(1'b0, 8'h00);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 9) < 3) ? 8'h00 : W'($urandom());
            step(($urandom_range(0, 24) == 0), v);
        end
        for (int i = 0; i < D + 2; i++) step(1'b0, 8'h00);
        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
